gate_stim_checker: RTL and testbench

- Self-checking stimulus/response stage wrapped around the two-input logic_gates block (inputs a, b; outputs and_out, or_out, not_out).
- Upstream role: sequences the four input vectors onto a/b with a programmable hold time.
- Downstream role: samples the three gate outputs and compares them against golden values.
- Reports per-vector fail flags, an error count and a pass/done summary, so the gate block can be exercised in hardware without a testbench.

---
 rtl/gate_stim_checker_if.sv | 12 +
 rtl/gate_stim_checker.sv | 113 +++++++++++
 tb/tb_gate_stim_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gate_stim_checker_if.sv
// Stimulus/response bus between the checker and the two-input gate block.
// The checker is the master: it drives a/b and receives the three gate outputs.
interface gate_stim_checker_if;
    logic a;
    logic b;
    logic and_out;
    logic or_out;
    logic not_out;

    modport master (output a, b, input and_out, or_out, not_out);
    modport slave  (input a, b, output and_out, or_out, not_out);
endinterface

// File: rtl/gate_stim_checker.sv
// Self-checking sweep of the two-input gate block: steps a/b through
// 00,01,10,11, holds each vector HOLD_CYCLES cycles, samples the gate
// outputs and compares them to golden and/or/not values.
module gate_stim_checker #(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    gate_stim_checker_if.master   gs,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            err_count,
    output logic [3:0]            fail_mask
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] hold_cnt;
    logic             a_q, b_q;
    logic             smp_and, smp_or, smp_not;
    logic             vec_fail;
    logic [1:0]       vec_nxt;

    assign gs.a = a_q;
    assign gs.b = b_q;

    // Golden comparison of the sampled outputs against the current vector.
    always_comb begin
        vec_fail = (smp_and != (vec[1] & vec[0])) ||
                   (smp_or  != (vec[1] | vec[0])) ||
                   (smp_not != ~vec[1]);
        vec_nxt  = vec + 2'd1;
    end

    // Sweep sequencer: all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 2'd0;
            hold_cnt  <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
            smp_and   <= 1'b0;
            smp_or    <= 1'b0;
            smp_not   <= 1'b0;
        end else begin
            case (state)
                // IDLE and DONE both launch a fresh sweep on start; DONE
                // otherwise keeps the summary of the last sweep visible.
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        vec       <= 2'd0;
                        hold_cnt  <= '0;
                        a_q       <= 1'b0;
                        b_q       <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        smp_and  <= gs.and_out;
                        smp_or   <= gs.or_out;
                        smp_not  <= gs.not_out;
                        hold_cnt <= '0;
                        state    <= CHECK;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                CHECK: begin
                    if (vec_fail) begin
                        err_count      <= err_count + 3'd1;
                        fail_mask[vec] <= 1'b1;
                    end
                    if (vec == 2'd3) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // The last vector's verdict is not in err_count yet.
                        pass  <= (err_count == 3'd0) && !vec_fail;
                        a_q   <= 1'b0;
                        b_q   <= 1'b0;
                    end else begin
                        vec   <= vec_nxt;
                        a_q   <= vec_nxt[1];
                        b_q   <= vec_nxt[0];
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench: gate models with injectable faults around two checkers
// (HOLD_CYCLES=10 and HOLD_CYCLES=1).
module tb_gate_stim_checker;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic f_and0, f_not1;

    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] mask0, mask1;

    int total = 0;
    int bad   = 0;

    gate_stim_checker_if g0 ();
    gate_stim_checker_if g1 ();

    // Gate block models; dut0's can be broken on purpose.
    assign g0.and_out = f_and0 ? 1'b0 : (g0.a & g0.b);
    assign g0.or_out  = g0.a | g0.b;
    assign g0.not_out = f_not1 ? 1'b1 : ~g0.a;
    assign g1.and_out = g1.a & g1.b;
    assign g1.or_out  = g1.a | g1.b;
    assign g1.not_out = ~g1.a;

    gate_stim_checker #(.HOLD_CYCLES(10), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .gs(g0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_mask(mask0)
    );

    gate_stim_checker #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .gs(g1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    always #5 clk = ~clk;

    // Selected-DUT view so one sweep task serves both instances.
    logic       sel;
    logic       s_a, s_b, s_busy, s_done, s_pass;
    logic [2:0] s_err;
    logic [3:0] s_mask;
    always_comb begin
        s_a    = sel ? g1.a   : g0.a;
        s_b    = sel ? g1.b   : g0.b;
        s_busy = sel ? busy1  : busy0;
        s_done = sel ? done1  : done0;
        s_pass = sel ? pass1  : pass0;
        s_err  = sel ? err1   : err0;
        s_mask = sel ? mask1  : mask0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Pulse start, follow a/b cycle by cycle, optionally pulse start again
    // at cycle restart_at, then check latency and the final summary.
    task automatic sweep(input int h, input int restart_at, input logic chk_ab,
                         input int exp_err, input int exp_mask, input logic exp_pass);
        int lat;
        int bound;
        int ab_bad;
        bit hit;
        lat    = 0;
        ab_bad = 0;
        hit    = 1'b0;
        bound  = 4 * (h + 1) + 20;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        chk("busy_after_start", {31'd0, s_busy}, 32'd1);
        chk("done_after_start", {31'd0, s_done}, 32'd0);
        chk("err_cleared",      {29'd0, s_err},  32'd0);
        for (int k = 0; k < bound; k++) begin
            set_start(k == restart_at);
            if (chk_ab && k < 4 * (h + 1)) begin
                if ({s_a, s_b} !== 2'(k / (h + 1))) ab_bad++;
            end
            if (s_done) begin
                hit = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        set_start(1'b0);
        if (!hit) chk("done_timeout", 32'd0, 32'd1);
        if (chk_ab) chk("ab_sequence_errs", ab_bad, 32'd0);
        chk("latency",   lat,                  4 * (h + 1));
        chk("busy_done", {31'd0, s_busy},      32'd0);
        chk("ab_done",   {30'd0, s_a, s_b},    32'd0);
        chk("pass",      {31'd0, s_pass},      {31'd0, exp_pass});
        chk("err_count", {29'd0, s_err},       exp_err);
        chk("fail_mask", {28'd0, s_mask},      exp_mask);
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        f_and0 = 1'b0; f_not1 = 1'b0; sel = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state of both instances.
        chk("rst_ab0",   {30'd0, g0.a, g0.b}, 32'd0);
        chk("rst_busy0", {31'd0, busy0},      32'd0);
        chk("rst_done0", {31'd0, done0},      32'd0);
        chk("rst_pass0", {31'd0, pass0},      32'd0);
        chk("rst_err0",  {29'd0, err0},       32'd0);
        chk("rst_mask0", {28'd0, mask0},      32'd0);
        chk("rst_done1", {31'd0, done1},      32'd0);

        // Clean sweep, HOLD_CYCLES=10.
        sweep(10, -1, 1'b1, 0, 4'b0000, 1'b1);

        // and_out stuck at 0: only 11 fails.
        f_and0 = 1'b1;
        sweep(10, -1, 1'b0, 1, 4'b1000, 1'b0);
        f_and0 = 1'b0;

        // not_out stuck at 1: 10 and 11 fail; summary holds in DONE.
        f_not1 = 1'b1;
        sweep(10, -1, 1'b0, 2, 4'b1100, 1'b0);
        f_not1 = 1'b0;
        repeat (3) tick();
        chk("hold_done", {31'd0, done0}, 32'd1);
        chk("hold_err",  {29'd0, err0},  32'd2);
        chk("hold_mask", {28'd0, mask0}, 32'd12);

        // Restart straight from DONE with the fault removed.
        sweep(10, -1, 1'b0, 0, 4'b0000, 1'b1);

        // Reset during vector 01 DRIVE aborts the sweep.
        f_not1 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (14) tick();
        chk("mid_ab_is_01", {30'd0, g0.a, g0.b}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ab",   {30'd0, g0.a, g0.b}, 32'd0);
        chk("abort_busy", {31'd0, busy0},      32'd0);
        chk("abort_done", {31'd0, done0},      32'd0);
        chk("abort_err",  {29'd0, err0},       32'd0);
        chk("abort_mask", {28'd0, mask0},      32'd0);
        f_not1 = 1'b0;
        tick();
        sweep(10, -1, 1'b1, 0, 4'b0000, 1'b1);

        // start pulsed during vector 10 is ignored.
        sweep(10, 25, 1'b1, 0, 4'b0000, 1'b1);

        // HOLD_CYCLES=1: each vector on a/b for 2 cycles, done after 8.
        sel = 1'b1;
        sweep(1, -1, 1'b1, 0, 4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
